demux14_rr_scheduler: RTL

- Round-robin scheduler that drives the 1-to-4 de-selector: oS1/oS0 feed its select inputs and oC feeds its data input.
- Accepts single-bit data tokens from one upstream source (valid/ready).
- Grants each token to the next requesting channel 0..3 in rotating order.
- Holds select and data stable for a fixed dwell, then inserts a break-before-make gap before the selects may change.

---
 rtl/demux14_rr_scheduler.sv | 112 +++++++++++
 1 files changed

// File: rtl/demux14_rr_scheduler.sv
// Round-robin scheduler feeding a 1-to-4 de-selector: grants one-bit tokens to requesting
// channels in rotation, holds select/data for HOLD_CYCLES with oEn high, then a low-oEn gap.
module demux14_rr_scheduler #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iValid,
  input  logic       iData,
  output logic       oReady,
  input  logic [3:0] iReq,
  output logic       oS1,
  output logic       oS0,
  output logic       oC,
  output logic       oEn,
  output logic [3:0] oGrant,
  output logic       oBusy,
  output logic [1:0] oDbgState
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t     r_state;
  logic [7:0] r_cnt;
  logic [1:0] r_ptr;

  logic       w_open;
  logic       w_accept;
  logic       w_hit;
  logic [1:0] w_cand;
  logic [1:0] w_idx;

  // Handshake: a token moves when iValid && oReady at a rising edge; oReady never
  // depends on iValid. The last GAP cycle is already open, so a new token lands exactly
  // GAP_CYCLES low-oEn cycles after the previous transfer ended.
  assign w_open    = (r_state == ST_IDLE) || ((r_state == ST_GAP) && (r_cnt == 8'd0));
  assign oReady    = !iRST && w_open && (|iReq);
  assign w_accept  = iValid && oReady;
  assign oDbgState = r_state;

  // First requester after the last-granted channel, wrapping modulo 4.
  always_comb begin
    w_idx  = r_ptr;
    w_hit  = 1'b0;
    w_cand = r_ptr;
    for (int k = 1; k <= 4; k++) begin
      w_cand = r_ptr + 2'(k);
      if (!w_hit && iReq[w_cand]) begin
        w_idx = w_cand;
        w_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state <= ST_IDLE;
      r_cnt   <= 8'd0;
      r_ptr   <= 2'd3;
      oS1     <= 1'b0;
      oS0     <= 1'b0;
      oC      <= 1'b0;
      oEn     <= 1'b0;
      oGrant  <= 4'b0000;
      oBusy   <= 1'b0;
    end else if (w_accept) begin
      oC      <= iData;
      oS1     <= w_idx[1];
      oS0     <= w_idx[0];
      oGrant  <= 4'b0001 << w_idx;
      oEn     <= 1'b1;
      oBusy   <= 1'b1;
      r_ptr   <= w_idx;
      r_cnt   <= 8'(HOLD_CYCLES - 1);
      r_state <= ST_HOLD;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_IDLE;
        end
        ST_HOLD: begin
          // Requests dropping here do not matter: the transfer always runs to term.
          if (r_cnt == 8'd0) begin
            oEn     <= 1'b0;
            oGrant  <= 4'b0000;
            r_cnt   <= 8'(GAP_CYCLES - 1);
            r_state <= ST_GAP;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        ST_GAP: begin
          if (r_cnt == 8'd0) begin
            oBusy   <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
